// File: rtl/magnitude_comparator_serial.sv
// magnitude_comparator_serial
// Digit-serial magnitude comparator: compares two WIDTH-bit operands DIGIT
// bits per cycle, most-significant digit first, unsigned or two's-complement.
// Results are one-hot lt/gt/eq flags.
//
// Handshake rules for both ports:
// - A transfer happens on a rising edge where valid && ready.
// - in_ready is high only in IDLE.
// - While out_valid is high and out_ready is low, the flags and out_valid
//   stay stable.
//
// Optional build macro COMPARE_EARLY_EXIT_EN: when defined, the compare ends
// on the edge that records the first unequal digit. When undefined, every
// compare takes NUM_STEPS cycles (constant time). The result flags are the
// same in both builds.
module magnitude_comparator_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [1:0]       dbg_state
);

  localparam int NUM_STEPS = WIDTH / DIGIT;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             lt_q, gt_q, eq_q, decided_q;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_differs, dig_lt;

  // Current digit pair. The operand registers shift left each step, so the
  // digit under test always sits at the top. On the first step of a signed
  // compare, both sign bits are flipped so an unsigned compare orders
  // two's-complement values correctly.
  always_comb begin
    a_dig = a_q[WIDTH-1 -: DIGIT];
    b_dig = b_q[WIDTH-1 -: DIGIT];
    if (signed_q && (step_q == '0)) begin
      a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
      b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
    end
    dig_differs = (a_dig != b_dig);
    dig_lt      = (a_dig < b_dig);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (step_q == LAST_STEP) state_d = S_DONE;
`ifdef COMPARE_EARLY_EXIT_EN
        if (!decided_q && dig_differs) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registers only. The flags are masked
  // outside DONE, so a decision recorded mid-compare never leaks out.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    lt        = out_valid & lt_q;
    gt        = out_valid & gt_q;
    eq        = out_valid & eq_q;
    dbg_state = state_q;
  end

  // Operand capture, digit stepping and decision recording.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      decided_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            signed_q  <= signed_mode;
            step_q    <= '0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            decided_q <= 1'b0;
          end
        end
        S_COMPARE: begin
          a_q    <= a_q << DIGIT;
          b_q    <= b_q << DIGIT;
          step_q <= step_q + CNT_W'(1);
          // The first unequal digit decides. Later digits are ignored.
          if (!decided_q && dig_differs) begin
            decided_q <= 1'b1;
            lt_q      <= dig_lt;
            gt_q      <= ~dig_lt;
          end
          // If every digit matched, the operands are equal.
          if ((state_d == S_DONE) && !decided_q && !dig_differs) begin
            eq_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_comparator_serial.sv
// tb_magnitude_comparator_serial
// Directed bench for magnitude_comparator_serial (WIDTH=16, DIGIT=4).
// A behavioural model predicts flags and latency from plain signed/unsigned
// arithmetic. A negedge scoreboard checks every cycle. Directed tasks pin
// hand-computed literal results and latencies for both builds
// (COMPARE_EARLY_EXIT_EN defined or not).
module tb_magnitude_comparator_serial;

  localparam int WIDTH     = 16;
  localparam int DIGIT     = 4;
  localparam int NUM_STEPS = WIDTH / DIGIT;
  localparam logic [2:0] F_LT = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic             lt, gt, eq;
  logic [1:0]       dbg_state;

  magnitude_comparator_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lt         (lt),
    .gt         (gt),
    .eq         (eq),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [2:0] exp_q[$];
  int         lat_q[$];
  int         acc_q[$];
  logic [2:0] res_log[$];
  logic       prev_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
    if (s) begin
      if ($signed(x) < $signed(y)) return F_LT;
      if ($signed(x) > $signed(y)) return F_GT;
      return F_EQ;
    end
    if (x < y) return F_LT;
    if (x > y) return F_GT;
    return F_EQ;
  endfunction

  // Cycles from the accepting edge to out_valid.
  function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int k;
    k = NUM_STEPS;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (x[(NUM_STEPS-1-i)*DIGIT +: DIGIT] != y[(NUM_STEPS-1-i)*DIGIT +: DIGIT]) k = i + 1;
    end
`ifndef COMPARE_EARLY_EXIT_EN
    k = NUM_STEPS;
`endif
    return k;
  endfunction

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {lt, gt, eq}, 0);
        check("rst_in_ready", in_ready, 1);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        prev_ov = 1'b0;
      end else begin
        if (out_valid) begin
          check("done_in_ready", in_ready, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got flags %b with no pending operation", {lt, gt, eq});
          end else begin
            if (!prev_ov) check("sb_latency", cyc - acc_q[0] - 1, lat_q[0]);
            check("sb_flags", {lt, gt, eq}, exp_q[0]);
            if (out_ready) begin
              res_log.push_back({lt, gt, eq});
              void'(exp_q.pop_front());
              void'(lat_q.pop_front());
              void'(acc_q.pop_front());
            end
          end
        end else begin
          check("idle_flags", {lt, gt, eq}, 0);
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model_flags(a, b, signed_mode));
          lat_q.push_back(model_lat(a, b));
          acc_q.push_back(cyc);
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present operands until accepted. Returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic s,
                      input bit hold, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    a = va;
    b = vb;
    signed_mode = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never high for a=%h b=%h", va, vb);
    end
  endtask

  task automatic do_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic s, input logic [2:0] ef, input int lat_off, input int lat_early);
    int  n;
    int  acc;
    bit  got;
    int  el;
`ifdef COMPARE_EARLY_EXIT_EN
    el = lat_early;
`else
    el = lat_off;
`endif
    out_ready = 1'b1;
    send(va, vb, s, 1'b0, acc);
    got = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        n = i;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid never rose", name);
    end else begin
      check({name, "_flags"}, {lt, gt, eq}, ef);
      check({name, "_latency"}, n - 1, el);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, acc3;
    bit got;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_flags", {lt, gt, eq}, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_state", dbg_state, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic unsigned/signed cases (latency: feature off, feature on)
    do_op("t1_lt",      16'h1234, 16'h1235, 1'b0, F_LT, 4, 4);
    do_op("t2_uns_gt",  16'h8000, 16'h0001, 1'b0, F_GT, 4, 1);
    do_op("t2_sgn_lt",  16'h8000, 16'h0001, 1'b1, F_LT, 4, 1);
    do_op("t3_uns_eq",  16'hFFFF, 16'hFFFF, 1'b0, F_EQ, 4, 4);
    do_op("t3_sgn_eq",  16'hFFFF, 16'hFFFF, 1'b1, F_EQ, 4, 4);
    do_op("t3_sgn_gt",  16'h7FFF, 16'hFFFF, 1'b1, F_GT, 4, 1);
    do_op("x_sgn_neg",  16'hFFFF, 16'h0000, 1'b1, F_LT, 4, 1);
    do_op("x_uns_lt",   16'h0000, 16'hFFFF, 1'b0, F_LT, 4, 1);
    do_op("x_sgn_low",  16'h8001, 16'h8000, 1'b1, F_GT, 4, 4);
    do_op("x_sgn_mid",  16'h7F00, 16'h7E00, 1'b1, F_GT, 4, 2);

    // Backpressure in DONE while new operands are pulsed.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F00, 1'b0, 1'b0, acc1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bp_timeout: out_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      signed_mode = i[0];
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_flags", {lt, gt, eq}, F_LT);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_valid", out_valid, 0);
    check("bp_after_in_ready", in_ready, 1);

    // Asynchronous reset during COMPARE step 2.
    @(posedge clk);
    #1;
    send(16'h1234, 16'h1235, 1'b0, 1'b0, acc1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_state", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_flags", {lt, gt, eq}, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    do_op("t5_lt", 16'h0010, 16'h0100, 1'b0, F_LT, 4, 2);

    // Back-to-back with in_valid held high.
    res_log.delete();
    out_ready = 1'b1;
    send(16'h0001, 16'h0000, 1'b0, 1'b1, acc1);
    send(16'h0000, 16'h0000, 1'b0, 1'b1, acc2);
    send(16'hFFFE, 16'hFFFF, 1'b0, 1'b0, acc3);
    check("b2b_spacing_1", acc2 - acc1, NUM_STEPS + 2);
    check("b2b_spacing_2", acc3 - acc2, NUM_STEPS + 2);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_count", res_log.size(), 3);
    if (res_log.size() == 3) begin
      check("b2b_res0", res_log[0], F_GT);
      check("b2b_res1", res_log[1], F_EQ);
      check("b2b_res2", res_log[2], F_LT);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
